// File: rtl/usb_slfifo_sched.sv
// Slave-FIFO bus scheduler for the CY68013: round-robin sharing of the FD bus
// between an EP2 read stream and an EP6 write stream, with parameterised strobe timing.
module usb_slfifo_sched #(
    parameter int unsigned T_ADDR = 4,
    parameter int unsigned T_OE   = 8,
    parameter int unsigned T_RD   = 24,
    parameter int unsigned T_WR   = 24,
    parameter int unsigned T_HOLD = 8
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        usb_flaga,
    input  logic        usb_flagc,
    output logic [1:0]  usb_fifoaddr,
    output logic        usb_slcs,
    output logic        usb_sloe,
    output logic        usb_slrd,
    output logic        usb_slwr,
    input  logic [15:0] usb_fd_i,
    output logic [15:0] usb_fd_o,
    output logic        usb_fd_oe,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_ADDR = 4'd1,
        S_RD_OE   = 4'd2,
        S_RD_STRB = 4'd3,
        S_RD_HOLD = 4'd4,
        S_WR_ADDR = 4'd5,
        S_WR_STRB = 4'd6,
        S_WR_HOLD = 4'd7
    } state_t;

    // Phase counter loads N-1 on entry and the state exits when it reaches zero.
    localparam logic [5:0] LD_ADDR = 6'(T_ADDR - 32'd1);
    localparam logic [5:0] LD_OE   = 6'(T_OE   - 32'd1);
    localparam logic [5:0] LD_RD   = 6'(T_RD   - 32'd1);
    localparam logic [5:0] LD_WR   = 6'(T_WR   - 32'd1);
    localparam logic [5:0] LD_HOLD = 6'(T_HOLD - 32'd1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last_wr_q, last_wr_d;
    logic        flaga_meta_q, flaga_meta_d, flaga_sync_q, flaga_sync_d;
    logic        flagc_meta_q, flagc_meta_d, flagc_sync_q, flagc_sync_d;
    logic [1:0]  fifoaddr_q, fifoaddr_d;
    logic        sloe_q, sloe_d, slrd_q, slrd_d, slwr_q, slwr_d;
    logic        fd_oe_q, fd_oe_d, busy_q, busy_d;
    logic [15:0] fd_o_q, fd_o_d, rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic        rd_elig_s, wr_elig_s, grant_wr_s;

    // Next-state, arbitration and datapath capture.
    always_comb begin
        flaga_meta_d = usb_flaga;
        flaga_sync_d = flaga_meta_q;
        flagc_meta_d = usb_flagc;
        flagc_sync_d = flagc_meta_q;
        rd_elig_s    = enable & flaga_sync_q & ~rd_valid_q;
        wr_elig_s    = enable & flagc_sync_q & wr_valid;
        grant_wr_s   = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_wr_d    = last_wr_q;
        fd_o_d       = fd_o_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q & ~rd_ready;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        case (state_q)
            S_IDLE: begin
                // A contested grant goes to the channel that did not win last time.
                if (rd_elig_s && (!wr_elig_s || last_wr_q)) begin
                    state_d   = S_RD_ADDR;
                    cnt_d     = LD_ADDR;
                    last_wr_d = 1'b0;
                end else if (wr_elig_s) begin
                    grant_wr_s = 1'b1;
                    state_d    = S_WR_ADDR;
                    cnt_d      = LD_ADDR;
                    last_wr_d  = 1'b1;
                    fd_o_d     = wr_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (cnt_q == 6'd0) begin state_d = S_RD_OE; cnt_d = LD_OE; end
                else begin cnt_d = cnt_q - 6'd1; end
            end
            S_RD_OE: begin
                if (cnt_q == 6'd0) begin state_d = S_RD_STRB; cnt_d = LD_RD; end
                else begin cnt_d = cnt_q - 6'd1; end
            end
            S_RD_STRB: begin
                if (cnt_q == 6'd0) begin
                    state_d   = S_RD_HOLD;
                    cnt_d     = LD_HOLD;
                    rd_data_d = usb_fd_i;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_RD_HOLD: begin
                if (cnt_q == 6'd0) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b1;
                    rd_count_d = rd_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_WR_ADDR: begin
                if (cnt_q == 6'd0) begin state_d = S_WR_STRB; cnt_d = LD_WR; end
                else begin cnt_d = cnt_q - 6'd1; end
            end
            S_WR_STRB: begin
                if (cnt_q == 6'd0) begin state_d = S_WR_HOLD; cnt_d = LD_HOLD; end
                else begin cnt_d = cnt_q - 6'd1; end
            end
            S_WR_HOLD: begin
                if (cnt_q == 6'd0) begin
                    state_d    = S_IDLE;
                    wr_count_d = wr_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Bus pins decoded from the next state so they are registered alongside it.
    always_comb begin
        fifoaddr_d = 2'b00;
        sloe_d     = 1'b1;
        slrd_d     = 1'b1;
        slwr_d     = 1'b1;
        fd_oe_d    = 1'b0;
        busy_d     = 1'b1;
        case (state_d)
            S_IDLE:    busy_d = 1'b0;
            S_RD_ADDR: busy_d = 1'b1;
            S_RD_OE:   sloe_d = 1'b0;
            S_RD_STRB: begin sloe_d = 1'b0; slrd_d = 1'b0; end
            S_RD_HOLD: sloe_d = 1'b0;
            S_WR_ADDR: begin fifoaddr_d = 2'b10; fd_oe_d = 1'b1; end
            S_WR_STRB: begin fifoaddr_d = 2'b10; fd_oe_d = 1'b1; slwr_d = 1'b0; end
            S_WR_HOLD: begin fifoaddr_d = 2'b10; fd_oe_d = 1'b1; end
            default:   busy_d = 1'b0;
        endcase
    end

    // State and registered outputs; reset forces the bus to its quiet state at once.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 6'd0;
            last_wr_q    <= 1'b1;
            flaga_meta_q <= 1'b0;
            flaga_sync_q <= 1'b0;
            flagc_meta_q <= 1'b0;
            flagc_sync_q <= 1'b0;
            fifoaddr_q   <= 2'b00;
            sloe_q       <= 1'b1;
            slrd_q       <= 1'b1;
            slwr_q       <= 1'b1;
            fd_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
            fd_o_q       <= 16'd0;
            rd_data_q    <= 16'd0;
            rd_valid_q   <= 1'b0;
            rd_count_q   <= 16'd0;
            wr_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_wr_q    <= last_wr_d;
            flaga_meta_q <= flaga_meta_d;
            flaga_sync_q <= flaga_sync_d;
            flagc_meta_q <= flagc_meta_d;
            flagc_sync_q <= flagc_sync_d;
            fifoaddr_q   <= fifoaddr_d;
            sloe_q       <= sloe_d;
            slrd_q       <= slrd_d;
            slwr_q       <= slwr_d;
            fd_oe_q      <= fd_oe_d;
            busy_q       <= busy_d;
            fd_o_q       <= fd_o_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // wr_ready marks the grant cycle itself, the cycle in which wr_data is taken.
    assign wr_ready     = grant_wr_s;
    assign usb_slcs     = 1'b0;
    assign usb_fifoaddr = fifoaddr_q;
    assign usb_sloe     = sloe_q;
    assign usb_slrd     = slrd_q;
    assign usb_slwr     = slwr_q;
    assign usb_fd_o     = fd_o_q;
    assign usb_fd_oe    = fd_oe_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign busy         = busy_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_usb_slfifo_sched.sv
// Self-checking bench for usb_slfifo_sched: a transaction-offset reference model
// predicts every bus pin each cycle; scenario tasks add targeted timing checks.
module tb_usb_slfifo_sched;
    localparam int TA = 4, TO = 8, TR = 24, TW = 24, TH = 8;
    localparam int LEN_RD = TA + TO + TR + TH;
    localparam int LEN_WR = TA + TW + TH;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0, usb_flaga = 1'b0, usb_flagc = 1'b0;
    logic        rd_ready = 1'b0, wr_valid = 1'b0;
    logic [15:0] usb_fd_i = 16'd0, wr_data = 16'd0;
    logic [1:0]  usb_fifoaddr;
    logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe;
    logic [15:0] usb_fd_o, rd_data, rd_count, wr_count;
    logic        rd_valid, wr_ready, busy;
    int          n_chk = 0, n_fail = 0;

    usb_slfifo_sched #(.T_ADDR(TA), .T_OE(TO), .T_RD(TR), .T_WR(TW), .T_HOLD(TH)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable),
        .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
        .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
        .usb_slrd(usb_slrd), .usb_slwr(usb_slwr),
        .usb_fd_i(usb_fd_i), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 sys_clk = ~sys_clk;

    logic [8:0]  ctl;
    logic [63:0] dat;
    assign ctl = {usb_fifoaddr, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe, busy, wr_ready, rd_valid};
    assign dat = {rd_data, usb_fd_o, rd_count, wr_count};

    // Reference model: kind 0 idle / 1 read / 2 write, k = cycle offset inside the transaction.
    int          m_kind, m_k;
    logic        fa1, fa2, fc1, fc2, m_rdv, m_last_wr;
    logic [15:0] m_rd_data, m_fd_o, m_rdc, m_wrc;

    function automatic logic [1:0] model_grant();
        logic rd_e, wr_e, gr, gw;
        rd_e = enable & fa2 & ~m_rdv;
        wr_e = enable & fc2 & wr_valid;
        gr   = (m_kind == 0) && rd_e && (!wr_e || m_last_wr);
        gw   = (m_kind == 0) && wr_e && !gr;
        return {gr, gw};
    endfunction

    function automatic logic [8:0] exp_ctl();
        logic [1:0] g, fa;
        logic sloe, slrd, slwr, oe, bsy;
        g = model_grant();
        fa = 2'b00; sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; oe = 1'b0; bsy = 1'b0;
        if (m_kind == 1) begin
            bsy  = 1'b1;
            sloe = !(m_k >= TA);
            slrd = !(m_k >= TA + TO && m_k < TA + TO + TR);
        end else if (m_kind == 2) begin
            bsy  = 1'b1; fa = 2'b10; oe = 1'b1;
            slwr = !(m_k >= TA && m_k < TA + TW);
        end
        return {fa, sloe, slrd, slwr, oe, bsy, g[0], m_rdv};
    endfunction

    function automatic logic [63:0] exp_dat();
        return {m_rd_data, m_fd_o, m_rdc, m_wrc};
    endfunction

    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_kind = 0; m_k = 0; fa1 = 1'b0; fa2 = 1'b0; fc1 = 1'b0; fc2 = 1'b0;
            m_rdv = 1'b0; m_last_wr = 1'b1; m_rd_data = 16'd0; m_fd_o = 16'd0;
            m_rdc = 16'd0; m_wrc = 16'd0;
        end else begin
            logic [1:0] g;
            logic nrdv;
            g = model_grant();
            nrdv = m_rdv & ~rd_ready;
            if (m_kind == 1 && m_k == TA + TO + TR - 1) m_rd_data = usb_fd_i;
            if (m_kind != 0) begin
                m_k++;
                if (m_kind == 1 && m_k == LEN_RD) begin
                    m_kind = 0; nrdv = 1'b1; m_rdc = m_rdc + 16'd1;
                end else if (m_kind == 2 && m_k == LEN_WR) begin
                    m_kind = 0; m_wrc = m_wrc + 16'd1;
                end
            end else if (g[1]) begin
                m_kind = 1; m_k = 0; m_last_wr = 1'b0;
            end else if (g[0]) begin
                m_kind = 2; m_k = 0; m_last_wr = 1'b1; m_fd_o = wr_data;
            end
            m_rdv = nrdv;
            fa2 = fa1; fa1 = usb_flaga; fc2 = fc1; fc1 = usb_flagc;
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        reset_n = 1'b0; enable = 1'b0; usb_flaga = 1'b0; usb_flagc = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        usb_flaga = 1'b1; usb_flagc = 1'b1; wr_valid = 1'b1; enable = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_chk++; if (ctl !== 9'b001110000) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 9'b001110000); end
        n_chk++; if (dat !== 64'd0) begin n_fail++; $display("FAIL reset_dat got=%h exp=0", dat); end
        n_chk++; if (usb_slcs !== 1'b0) begin n_fail++; $display("FAIL reset_slcs got=%b exp=0", usb_slcs); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        int t_busy = -1, t_oe = -1, t_val = -1, n_rd = 0;
        do_reset();
        enable = 1'b1; usb_flaga = 1'b1; rd_ready = 1'b1; usb_fd_i = 16'hA5C3;
        for (int t = 0; t < 80; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL rd_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (dat !== exp_dat()) begin n_fail++; $display("FAIL rd_dat t=%0t got=%h exp=%h", $time, dat, exp_dat()); end
            if (busy && t_busy < 0) begin t_busy = t; usb_flaga = 1'b0; end
            if (!usb_sloe && t_oe < 0) t_oe = t;
            if (!usb_slrd) n_rd++;
            if (rd_valid && t_val < 0) t_val = t;
        end
        n_chk++; if (t_busy < 0) begin n_fail++; $display("FAIL rd_grant_timeout got=none exp=grant"); end
        n_chk++; if (t_oe - t_busy !== TA) begin n_fail++; $display("FAIL rd_sloe_delay got=%0d exp=%0d", t_oe - t_busy, TA); end
        n_chk++; if (n_rd !== TR) begin n_fail++; $display("FAIL rd_slrd_width got=%0d exp=%0d", n_rd, TR); end
        n_chk++; if (t_val - t_busy + 1 !== 45) begin n_fail++; $display("FAIL rd_valid_latency got=%0d exp=45", t_val - t_busy + 1); end
        n_chk++; if (rd_data !== 16'hA5C3) begin n_fail++; $display("FAIL rd_data got=%h exp=a5c3", rd_data); end
        n_chk++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL rd_count got=%0d exp=1", rd_count); end
    endtask

    task automatic test_single_write();
        int n_rdy = 0, n_wr = 0, n_oe = 0;
        do_reset();
        enable = 1'b1; usb_flagc = 1'b1; wr_valid = 1'b1; wr_data = 16'h1234;
        for (int t = 0; t < 70; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL wr_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (dat !== exp_dat()) begin n_fail++; $display("FAIL wr_dat t=%0t got=%h exp=%h", $time, dat, exp_dat()); end
            if (!usb_slwr) n_wr++;
            if (usb_fd_oe) begin
                n_oe++;
                n_chk++; if (usb_fd_o !== 16'h1234 || usb_fifoaddr !== 2'b10) begin
                    n_fail++; $display("FAIL wr_bus got=%h/%b exp=1234/10", usb_fd_o, usb_fifoaddr);
                end
            end
            if (wr_ready) begin
                n_rdy++;
                @(posedge sys_clk); #1; wr_valid = 1'b0; wr_data = 16'hDEAD;
            end
        end
        n_chk++; if (n_rdy !== 1) begin n_fail++; $display("FAIL wr_ready_pulses got=%0d exp=1", n_rdy); end
        n_chk++; if (n_wr !== TW) begin n_fail++; $display("FAIL wr_slwr_width got=%0d exp=%0d", n_wr, TW); end
        n_chk++; if (n_oe !== TA + TW + TH) begin n_fail++; $display("FAIL wr_oe_width got=%0d exp=%0d", n_oe, TA + TW + TH); end
        n_chk++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL wr_count got=%0d exp=1", wr_count); end
    endtask

    task automatic test_contention();
        int order[$];
        logic prev_busy = 1'b0;
        do_reset();
        enable = 1'b1; usb_flaga = 1'b1; usb_flagc = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
        wr_data = 16'($urandom);
        for (int t = 0; t < 6 * 50 && order.size() < 6; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL cont_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (usb_fd_oe && !usb_sloe) begin n_fail++; $display("FAIL cont_bus_clash got=oe1_sloe0 exp=exclusive"); end
            if (busy && !prev_busy) order.push_back(usb_fifoaddr == 2'b10 ? 2 : 1);
            prev_busy = busy;
            if (wr_ready) begin @(posedge sys_clk); #1; wr_data = 16'($urandom); end
        end
        n_chk++; if (order.size() !== 6) begin n_fail++; $display("FAIL cont_count got=%0d exp=6", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_chk++; if (order[i] !== ((i % 2 == 0) ? 1 : 2)) begin
                n_fail++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, order[i], (i % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int order[$];
        int exp_order[5] = '{1, 2, 2, 2, 1};
        logic prev_busy = 1'b0;
        do_reset();
        enable = 1'b1; usb_flaga = 1'b1; usb_flagc = 1'b1; wr_valid = 1'b1; rd_ready = 1'b0;
        for (int t = 0; t < 5 * 50 && order.size() < 5; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL bp_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (dat !== exp_dat()) begin n_fail++; $display("FAIL bp_dat t=%0t got=%h exp=%h", $time, dat, exp_dat()); end
            if (busy && !prev_busy) order.push_back(usb_fifoaddr == 2'b10 ? 2 : 1);
            prev_busy = busy;
            if (order.size() == 4) rd_ready = 1'b1;
        end
        n_chk++; if (order.size() !== 5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_chk++; if (order[i] !== exp_order[i]) begin
                n_fail++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1; rd_ready = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            @(posedge sys_clk); #1;
            usb_fd_i = 16'($urandom);
            if ($urandom_range(15) == 0) usb_flaga = ~usb_flaga;
            if ($urandom_range(15) == 0) usb_flagc = ~usb_flagc;
            if ($urandom_range(7) == 0) wr_valid = ~wr_valid;
            if ($urandom_range(3) == 0) wr_data = 16'($urandom);
            rd_ready = ($urandom_range(3) != 0);
            enable = ($urandom_range(63) != 0);
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL rnd_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (dat !== exp_dat()) begin n_fail++; $display("FAIL rnd_dat t=%0t got=%h exp=%h", $time, dat, exp_dat()); end
        end
    endtask

    task automatic test_reset_mid_strobe();
        int n_strb = 0;
        logic prev_slrd = 1'b1;
        do_reset();
        enable = 1'b1; usb_flaga = 1'b1; rd_ready = 1'b1;
        for (int t = 0; t < 150 && n_strb < 2; t++) begin
            @(negedge sys_clk);
            if (!usb_slrd && prev_slrd) n_strb++;
            prev_slrd = usb_slrd;
        end
        n_chk++; if (n_strb !== 2) begin n_fail++; $display("FAIL rst_strobe_timeout got=%0d exp=2", n_strb); end
        n_chk++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL rst_pre_count got=%0d exp=1", rd_count); end
        repeat (9) @(negedge sys_clk);
        #2; reset_n = 1'b0;
        #1;
        n_chk++; if ({usb_slrd, usb_sloe, usb_fd_oe, busy} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_async got=%b exp=1100", {usb_slrd, usb_sloe, usb_fd_oe, busy});
        end
        usb_flaga = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== 9'b001110000) begin n_fail++; $display("FAIL rst_after_ctl got=%b exp=%b", ctl, 9'b001110000); end
            n_chk++; if ({rd_count, wr_count} !== 32'd0) begin n_fail++; $display("FAIL rst_after_counts got=%h exp=0", {rd_count, wr_count}); end
        end
    endtask

    task automatic test_wrap_enable();
        int n_done = 0, n_rise_off = 0;
        logic prev_busy = 1'b0, dis = 1'b0;
        do_reset();
        @(negedge sys_clk);
        force dut.wr_count_q = 16'hFFFF;
        m_wrc = 16'hFFFF;
        @(negedge sys_clk);
        release dut.wr_count_q;
        enable = 1'b1; usb_flagc = 1'b1; wr_valid = 1'b1; wr_data = 16'h5A5A;
        for (int t = 0; t < 130; t++) begin
            @(negedge sys_clk);
            n_chk++; if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL wrap_ctl t=%0t got=%b exp=%b", $time, ctl, exp_ctl()); end
            n_chk++; if (dat !== exp_dat()) begin n_fail++; $display("FAIL wrap_dat t=%0t got=%h exp=%h", $time, dat, exp_dat()); end
            if (!busy && prev_busy) begin
                n_done++;
                if (n_done == 1) begin
                    n_chk++; if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count got=%h exp=0000", wr_count); end
                end
            end
            if (busy && !prev_busy && dis) n_rise_off++;
            prev_busy = busy;
            if (n_done == 1 && !usb_slwr && !dis) begin enable = 1'b0; dis = 1'b1; end
        end
        n_chk++; if (n_done !== 2) begin n_fail++; $display("FAIL en_completions got=%0d exp=2", n_done); end
        n_chk++; if (n_rise_off !== 0) begin n_fail++; $display("FAIL en_grants_after_disable got=%0d exp=0", n_rise_off); end
        n_chk++; if (wr_count !== 16'h0001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL en_final got=%h/%b exp=0001/0", wr_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_mid_strobe();
        test_wrap_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_slfifo_sched.md
Name: usb_slfifo_sched

Overview:
Bus scheduler for the CY68013 slave-FIFO port. It shares the single 16-bit FD bus between two internal requesters:
- Read channel: EP2 to an FPGA consumer stream.
- Write channel: FPGA producer stream to EP6.

It uses round-robin arbitration and parameterised strobe timing, drives FIFOADR/SLCS/SLOE/SLRD/SLWR, and hands the FD tristate decision to the top level.

Parameters:
T_ADDR, 4, cycles FIFOADR is stable before OE/strobe (1..63)
T_OE, 8, cycles SLOE low before SLRD falls (1..63)
T_RD, 24, cycles SLRD held low (1..63)
T_WR, 24, cycles SLWR held low (1..63)
T_HOLD, 8, cycles after strobe release before the bus is freed (1..63)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = grants allowed; 0 = finish current transaction, then hold IDLE
usb_flaga  in  1  EP2 not-empty (1 = data available)
usb_flagc  in  1  EP6 not-full (1 = space available)
usb_fifoaddr  out  2  FIFO address: 00 = EP2, 10 = EP6
usb_slcs  out  1  chip select, constant 0 out of reset
usb_sloe  out  1  output enable, active low
usb_slrd  out  1  read strobe, active low
usb_slwr  out  1  write strobe, active low
usb_fd_i  in  16  FD bus input from top-level IOBUF
usb_fd_o  out  16  FD bus output data
usb_fd_oe  out  1  1 = top level drives usb_fd_o onto FD
rd_data  out  16  word read from EP2
rd_valid  out  1  rd_data valid, held until rd_ready
rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready
wr_data  in  16  word to write to EP6
wr_valid  in  1  producer has a word
wr_ready  out  1  one-cycle pulse: wr_data accepted this cycle
busy  out  1  1 whenever state != IDLE
rd_count  out  16  EP2 words read, wraps 0xFFFF to 0
wr_count  out  16  EP6 words written, wraps 0xFFFF to 0

Behaviour:
- Reset values (asynchronous, override everything, including mid-transaction):
  - usb_fifoaddr=00, usb_slcs=0, usb_sloe=1, usb_slrd=1, usb_slwr=1
  - usb_fd_oe=0, usb_fd_o=0, rd_data=0, rd_valid=0, wr_ready=0
  - busy=0, rd_count=0, wr_count=0
  - state=IDLE, last_grant=WRITE (first contested grant goes to READ)
- usb_flaga and usb_flagc pass through a 2-flop synchronizer; eligibility uses the synchronized values only.
- Eligibility, evaluated in IDLE:
  - rd_elig = enable & flaga_s & ~rd_valid
  - wr_elig = enable & flagc_s & wr_valid
- Arbitration:
  - Only one eligible: grant it.
  - Both eligible: grant the channel opposite last_grant, then update last_grant.
  - Neither eligible: stay IDLE.
  - The grant decision takes 1 cycle in IDLE.
- Phase counter is 6 bits. It reloads at each state entry; the state exits after exactly N cycles, N = the parameter for that state.
- Read sequence (usb_fifoaddr=00 throughout):
  - RD_ADDR: T_ADDR cycles, all strobes high.
  - RD_OE: T_OE cycles, sloe=0.
  - RD_STRB: T_RD cycles, sloe=0, slrd=0. usb_fd_i is captured into rd_data on the last cycle.
  - RD_HOLD: T_HOLD cycles, slrd=1, sloe=0.
  - Back to IDLE with sloe=1; rd_valid=1 and rd_count+1 in the same cycle.
  - Total with defaults: 1+4+8+24+8 = 45 cycles, IDLE to IDLE.
- Write sequence:
  - In the IDLE grant cycle, wr_ready pulses and wr_data is latched into usb_fd_o.
  - WR_ADDR: T_ADDR cycles, usb_fifoaddr=10, usb_fd_oe=1.
  - WR_STRB: T_WR cycles, slwr=0.
  - WR_HOLD: T_HOLD cycles, slwr=1, fd_oe stays 1.
  - Back to IDLE with fd_oe=0, usb_fifoaddr=00, wr_count+1.
  - Total with defaults: 1+4+24+8 = 37 cycles.
- Invariants:
  - usb_fd_oe and usb_sloe=0 are never asserted in the same cycle.
  - At least one IDLE cycle separates consecutive transactions.
  - usb_fifoaddr changes only in IDLE or at the IDLE-to-RD_ADDR/WR_ADDR transition.
- A flag deasserting mid-transaction does not abort it; it only affects the next eligibility check.
- rd_valid clears on the cycle after rd_valid & rd_ready. While rd_valid=1, reads are blocked and writes may still be granted.
- enable falling mid-transaction: the transaction completes normally, then the block stays in IDLE.
- Invalid state encoding returns to IDLE with all strobes high and fd_oe=0.

Test Plan:
- Single read: flaga=1, flagc=0, FD=0xA5C3, rd_ready=1 → sloe low 4 cycles after grant; slrd low exactly 24 cycles; rd_data=0xA5C3; rd_valid 45 cycles after grant start; rd_count=1.
- Single write: flaga=0, flagc=1, wr_data=0x1234 → wr_ready 1 pulse; fifoaddr=10; slwr low 24 cycles; fd_o=0x1234 with fd_oe=1 spanning the whole strobe plus 8-cycle hold; wr_count=1.
- Contention: flaga=flagc=1, wr_valid=1, rd_ready=1 for 6 transactions → grant order R,W,R,W,R,W; never sloe=0 while fd_oe=1.
- Backpressure: rd_ready=0 after the first read, both flags high → the second read is not granted; writes continue back-to-back; raising rd_ready re-enables reads.
- Reset mid-strobe: reset_n low during RD_STRB cycle 10 → slrd/sloe=1 and fd_oe=0 immediately (asynchronously); after release, state=IDLE and counts=0.
- Wrap and enable: preload via 65535 writes (or force) → wr_count wraps 0xFFFF to 0x0000; enable=0 during WR_STRB → write completes, no further grants.
